// File: rtl/fifo_req_ctrl_if.sv
// rtl/fifo_req_ctrl_if.sv - FIFO-side request/response bundle between the request controller and the 4-entry FIFO.
interface fifo_req_ctrl_if #(
  parameter int WL = 4
);
  logic          wReq;
  logic          rReq;
  logic [WL-1:0] din;
  logic          full;
  logic          empty;
  logic [WL-1:0] fifo_dout;

  modport master (
    output wReq, rReq, din,
    input  full, empty, fifo_dout
  );

  modport slave (
    input  wReq, rReq, din,
    output full, empty, fifo_dout
  );
endinterface

// File: rtl/fifo_req_ctrl.sv
// rtl/fifo_req_ctrl.sv - button debounce, arbitration and FIFO strobe generation for the display FIFO.
// Optional auto-repeat of held buttons is enabled by defining FIFO_CTRL_AUTOREPEAT_EN.
module fifo_req_ctrl #(
  parameter int WL            = 4,
  parameter int DB_CYCLES     = 16,
  parameter int REPEAT_CYCLES = 64
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            btn_wr,
  input  logic            btn_rd,
  input  logic [WL-1:0]   sw,
  fifo_req_ctrl_if.master fifo,
  output logic [WL-1:0]   disp,
  output logic            busy,
  output logic            drop
);

  localparam int CW = $clog2(DB_CYCLES) + 1;

  typedef enum logic [1:0] {IDLE, WRITE, READ, CAPTURE} state_t;

  state_t        state, state_nxt;
  // Index 0 is the write button, index 1 the read button.
  logic [1:0]    sync1, sync2, db, db_q, pend, clr_pend, rep_set;
  logic [CW-1:0] db_cnt [2];
  logic          rr_wr, rr_flip, sel_wr, drop_nxt, load_din, load_disp;
  logic [WL-1:0] din_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1  <= '0;
      sync2  <= '0;
      db     <= '0;
      db_q   <= '0;
      pend   <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= {btn_rd, btn_wr};
      sync2 <= sync1;
      db_q  <= db;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CW'(DB_CYCLES - 1)) begin
          db[i]     <= ~db[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
        // A set pend swallows further edges until the FSM consumes it.
        if (pend[i]) pend[i] <= ~clr_pend[i];
        else         pend[i] <= (db[i] & ~db_q[i]) | rep_set[i];
      end
    end
  end

`ifdef FIFO_CTRL_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES) + 1;
  logic [RW-1:0] rep_cnt [2];

  // The interval restarts each time a request for that button is served or dropped.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 2; i++) rep_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!db[i] || clr_pend[i] || rep_set[i]) rep_cnt[i] <= '0;
        else if (!pend[i])                        rep_cnt[i] <= rep_cnt[i] + 1'b1;
      end
    end
  end

  always_comb begin
    rep_set = '0;
    for (int i = 0; i < 2; i++)
      rep_set[i] = db[i] && !pend[i] && (rep_cnt[i] == RW'(REPEAT_CYCLES - 1));
  end
`else
  logic unused_repeat;
  assign rep_set       = '0;
  assign unused_repeat = ^REPEAT_CYCLES;
`endif

  // Round-robin pointer only moves on a contested decision.
  assign sel_wr = pend[0] & (~pend[1] | rr_wr);

  always_comb begin
    state_nxt = state;
    clr_pend  = '0;
    drop_nxt  = 1'b0;
    load_din  = 1'b0;
    load_disp = 1'b0;
    rr_flip   = 1'b0;
    case (state)
      IDLE: begin
        rr_flip = pend[0] & pend[1];
        if (sel_wr) begin
          clr_pend[0] = 1'b1;
          if (fifo.full) begin
            drop_nxt = 1'b1;
          end else begin
            state_nxt = WRITE;
            load_din  = 1'b1;
          end
        end else if (pend[1]) begin
          clr_pend[1] = 1'b1;
          if (fifo.empty) drop_nxt  = 1'b1;
          else            state_nxt = READ;
        end
      end
      WRITE:   state_nxt = IDLE;
      READ:    state_nxt = CAPTURE;
      CAPTURE: begin
        load_disp = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      rr_wr <= 1'b1;
      drop  <= 1'b0;
      din_q <= '0;
      disp  <= '0;
    end else begin
      state <= state_nxt;
      drop  <= drop_nxt;
      if (rr_flip)   rr_wr <= ~rr_wr;
      if (load_din)  din_q <= sw;
      if (load_disp) disp  <= fifo.fifo_dout;
    end
  end

  assign fifo.wReq = (state == WRITE);
  assign fifo.rReq = (state == READ);
  assign fifo.din  = din_q;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_fifo_req_ctrl.sv
// tb/tb_fifo_req_ctrl.sv - directed self-checking bench for fifo_req_ctrl.
module tb_fifo_req_ctrl;
  localparam int WL = 4;
  localparam int DB = 16;

  logic          CLK = 1'b0;
  logic          RST;
  logic          btn_wr, btn_rd;
  logic [WL-1:0] sw, disp, fifo_val;
  logic          busy, drop;

  fifo_req_ctrl_if #(.WL(WL)) fif ();

  fifo_req_ctrl #(.WL(WL), .DB_CYCLES(DB), .REPEAT_CYCLES(64)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .btn_wr (btn_wr),
    .btn_rd (btn_rd),
    .sw     (sw),
    .fifo   (fif),
    .disp   (disp),
    .busy   (busy),
    .drop   (drop)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Read data appears the cycle after rReq is sampled; zero otherwise.
  always @(posedge CLK) fif.fifo_dout <= fif.rReq ? fifo_val : '0;

  int            wr_cnt = 0, rd_cnt = 0, drop_cnt = 0, busy_cnt = 0;
  int            wr_cyc = 0, rd_cyc = 0, disp_cyc = 0;
  logic [WL-1:0] disp_prev = '0;
  always @(negedge CLK) begin
    if (!RST) begin
      if (fif.wReq) begin wr_cnt++; wr_cyc = cyc; end
      if (fif.rReq) begin rd_cnt++; rd_cyc = cyc; end
      if (drop) drop_cnt++;
      if (busy) busy_cnt++;
    end
    if (disp != disp_prev) disp_cyc = cyc;
    disp_prev = disp;
  end

  int checks = 0, errors = 0;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  int b_wr, b_rd, b_drop, b_busy, c0;
  task automatic snap();
    b_wr = wr_cnt; b_rd = rd_cnt; b_drop = drop_cnt; b_busy = busy_cnt; c0 = cyc;
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic press(input logic wr, input logic rd);
    snap();
    btn_wr = wr; btn_rd = rd;
    wait_n(30);
    btn_wr = 1'b0; btn_rd = 1'b0;
    wait_n(30);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    wait_n(3);
    RST = 1'b0;
    wait_n(2);
  endtask

  initial begin
    RST = 1'b1; btn_wr = 1'b0; btn_rd = 1'b0; sw = '0; fifo_val = '0;
    fif.full = 1'b0; fif.empty = 1'b1;
    wait_n(3);
    RST = 1'b0;
    @(negedge CLK);
    check("rst_wreq", fif.wReq, 0);
    check("rst_rreq", fif.rReq, 0);
    check("rst_din",  fif.din,  0);
    check("rst_disp", disp,     0);
    check("rst_busy", busy,     0);
    check("rst_drop", drop,     0);

    // single write
    sw = 4'hA;
    press(1'b1, 1'b0);
    check("wr_count",   wr_cnt - b_wr, 1);
    check("wr_latency", wr_cyc - c0, 2 + DB + 2);
    check("wr_din",     fif.din, 4'hA);
    check("wr_busy",    busy_cnt - b_busy, 1);
    check("wr_drop",    drop_cnt - b_drop, 0);

    // read capture
    fif.empty = 1'b0; fifo_val = 4'hA; sw = 4'h3;
    press(1'b0, 1'b1);
    check("rd_count",    rd_cnt - b_rd, 1);
    check("rd_disp",     disp, 4'hA);
    check("rd_disp_lat", disp_cyc - rd_cyc, 2);
    check("rd_busy",     busy_cnt - b_busy, 2);
    check("rd_din_hold", fif.din, 4'hA);

    // bounce shorter than the debounce window, then a real hold
    sw = 4'h5;
    snap();
    for (int i = 0; i < 3; i++) begin
      btn_wr = 1'b1; wait_n(DB - 1);
      btn_wr = 1'b0; wait_n(DB - 1);
    end
    check("bounce_none", wr_cnt - b_wr, 0);
    btn_wr = 1'b1; wait_n(30);
    btn_wr = 1'b0; wait_n(30);
    check("bounce_count", wr_cnt - b_wr, 1);
    check("bounce_din",   fif.din, 4'h5);

    // full refusal
    fif.full = 1'b1;
    press(1'b1, 1'b0);
    check("full_wreq", wr_cnt - b_wr, 0);
    check("full_drop", drop_cnt - b_drop, 1);
    check("full_busy", busy_cnt - b_busy, 0);
    fif.full = 1'b0;

    // empty refusal
    fif.empty = 1'b1;
    press(1'b0, 1'b1);
    check("empty_rreq", rd_cnt - b_rd, 0);
    check("empty_drop", drop_cnt - b_drop, 1);

    // simultaneous presses: write first after reset, read first next time
    do_reset();
    fif.empty = 1'b0; fifo_val = 4'h9;
    press(1'b1, 1'b1);
    check("sim1_wr",    wr_cnt - b_wr, 1);
    check("sim1_rd",    rd_cnt - b_rd, 1);
    check("sim1_order", rd_cyc - wr_cyc, 2);
    check("sim1_disp",  disp, 4'h9);
    press(1'b1, 1'b1);
    check("sim2_wr",    wr_cnt - b_wr, 1);
    check("sim2_rd",    rd_cnt - b_rd, 1);
    check("sim2_order", wr_cyc - rd_cyc, 3);

    // reset during the READ cycle
    do_reset();
    fifo_val = 4'h6;
    btn_rd = 1'b1;
    begin
      int found;
      found = 0;
      for (int i = 0; i < 40 && found == 0; i++) begin
        @(negedge CLK);
        if (fif.rReq) found = 1;
      end
      check("midrd_seen", found, 1);
    end
    #2 RST = 1'b1;
    #1;
    check("midrd_rreq", fif.rReq, 0);
    check("midrd_busy", busy, 0);
    btn_rd = 1'b0;
    wait_n(3);
    RST = 1'b0;
    snap();
    wait_n(50);
    check("midrd_no_rd",  rd_cnt - b_rd, 0);
    check("midrd_no_wr",  wr_cnt - b_wr, 0);
    check("midrd_disp",   disp, 0);
    check("midrd_nodrop", drop_cnt - b_drop, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_req_ctrl.md
# fifo_req_ctrl

Front-end request controller for the 4-entry FIFO used on the Basys 3 display path. It turns raw write/read push-buttons into clean single-cycle `wReq`/`rReq` pulses, and it captures switch data for each write. It arbitrates simultaneous requests and refuses requests the FIFO cannot accept. It also latches each read result for the BCD_7 display. It sits between the board inputs and the FIFO, on the same clock as the FIFO.

## Interface
- `WL`, 4, data word length (matches FIFO `WL`)
- `DB_CYCLES`, 16, consecutive stable samples required to accept a button level change (≥2)
- `REPEAT_CYCLES`, 64, auto-repeat interval in cycles (used only with the macro below)

- `CLK`  in  1  clock; all logic on rising edge
- `RST`  in  1  reset, asynchronous, active-high
- `btn_wr`  in  1  raw write button, asynchronous to `CLK`
- `btn_rd`  in  1  raw read button, asynchronous to `CLK`
- `sw`  in  WL  data switches
- `full`  in  1  FIFO full flag
- `empty`  in  1  FIFO empty flag
- `fifo_dout`  in  WL  FIFO read data; valid the cycle after `rReq` is sampled
- `wReq`  out  1  one-cycle FIFO write strobe
- `rReq`  out  1  one-cycle FIFO read strobe
- `din`  out  WL  FIFO write data; stable while `wReq`=1
- `disp`  out  WL  last value read from the FIFO
- `busy`  out  1  high whenever FSM ≠ IDLE
- `drop`  out  1  one-cycle pulse when a request is refused (full on write, empty on read)

## Operation
- **Input synchronisation:** each button passes through a 2-flop synchroniser.
- **Debounce:**
  - Each button has a counter of width clog2(DB_CYCLES)+1 and a debounced level `db_*`.
  - The counter clears on any sample that equals `db_*`.
  - The counter increments on a sample that differs from `db_*`.
  - When it reaches DB_CYCLES, `db_*` toggles and the counter clears.
- **Edge capture:**
  - A rising edge of `db_*` sets `pend_*` (one deep per button).
  - Edges arriving while `pend_*`=1 are discarded.
  - `pend_*` clears when the FSM leaves IDLE to serve it, or on a refusal.
- **Arbitration:**
  - If both pends are set in IDLE, round-robin applies: the side not served last wins.
  - After reset, write has priority.
- **FSM** (states IDLE, WRITE, READ, CAPTURE):
  - IDLE, write selected, `full`=0 → WRITE. On the transition edge, `din`<=`sw`.
  - IDLE, write selected, `full`=1 → stay IDLE. `drop` pulses next cycle and `pend_wr` clears.
  - IDLE, read selected, `empty`=0 → READ.
  - IDLE, read selected, `empty`=1 → stay IDLE. `drop` pulses and `pend_rd` clears.
  - WRITE: `wReq`=1 for this single cycle → IDLE.
  - READ: `rReq`=1 for this single cycle → CAPTURE.
  - CAPTURE: `disp`<=`fifo_dout` on the exiting edge → IDLE.
- **Outputs:** `wReq`, `rReq`, `busy` and `drop` decode registered state/flags only. No combinational path exists from any input to an output.
- **Reset values:** `wReq`=0, `rReq`=0, `din`=0, `disp`=0, `busy`=0, `drop`=0. FSM=IDLE, `db_*`=0, pends=0, counters=0, round-robin=write.

## Timing
- `db_wr` rises at edge k → `pend_wr`=1 after edge k+1 → WRITE, `wReq`=1 in cycle after edge k+2.
- A read follows the same timing for `rReq`. `disp` updates 2 cycles after the `rReq` cycle.
- Raw-press to strobe latency: 2 (sync) + DB_CYCLES + 2 cycles, provided the FSM is idle.
- Per-transaction occupancy: write 1 cycle outside IDLE, read 2 cycles. The minimum IDLE gap between transactions is 1 cycle.
- `full`/`empty` are sampled only in IDLE on the decision cycle.
- **Simultaneous edges:** both pends set in the same cycle. Winner per round-robin, the loser is served on the next IDLE cycle.
- **Reset asserted mid-transaction:** all outputs drop to reset values immediately (asynchronously), any strobe is truncated, and pending requests are lost.
- Bounce shorter than DB_CYCLES consecutive samples never changes `db_*`.

## Configuration
- `FIFO_CTRL_AUTOREPEAT_EN` defined:
  - While `db_*` stays high, `pend_*` re-sets every REPEAT_CYCLES cycles, counted from the cycle the previous request for that button was served or dropped.
  - The repeat counter clears when `db_*` falls.
- Not defined: exactly one request per debounced press. `REPEAT_CYCLES` is unused and no repeat counters are built.

## Test plan
- **Reset, then single write:** reset, `sw`=4'hA, clean `btn_wr` press (empty FIFO) → one `wReq` pulse, `din`=4'hA, `busy` high 1 cycle, `drop`=0.
- **Read capture:** FIFO holding 4'hA, press `btn_rd` → one `rReq`. `fifo_dout`=4'hA is presented the next cycle, and `disp`=4'hA two cycles after `rReq`.
- **Bounce rejection:** `btn_wr` toggles with pulses of DB_CYCLES−1 cycles, then is held → exactly one `wReq`.
- **Boundaries:**
  - `full`=1 with write press → no `wReq`, one `drop` pulse.
  - `empty`=1 with read press → no `rReq`, one `drop` pulse.
- **Simultaneous presses:** both buttons debounce in the same cycle after reset → WRITE first, READ served 2 cycles later (its `rReq` 2 cycles after the `wReq` cycle). A second simultaneous pair is served READ first.
- **Reset mid-read:** assert `RST` during the READ cycle → `rReq` falls without waiting for an edge, `disp` stays 0, and no request issues after release.
